// File: rtl/press_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : press_conditioner
// Brief    : Per-key 2-flop synchroniser, debounce FSM and one-shot press pulse.
//            Optional macro TIE_CANCEL_EN suppresses coincident pulses.
// Revision : 1.0 - initial release
// ============================================================================
module press_conditioner #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] held
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_CONF_PRESS = 2'd1;
    localparam logic [1:0] c_HELD       = 2'd2;
    localparam logic [1:0] c_CONF_REL   = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [N_KEYS-1:0] r_s1;
    logic [N_KEYS-1:0] r_s2;
    logic [N_KEYS-1:0] r_pulse;
    logic [N_KEYS-1:0] r_held;
    logic [N_KEYS-1:0] w_fire;
    logic [N_KEYS-1:0] w_held_nxt;
    logic [N_KEYS-1:0] w_pulse_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_pulse <= '0;
            r_held  <= '0;
        end else begin
            r_s1    <= key_raw;
            r_s2    <= r_s1;
            r_pulse <= w_pulse_nxt;
            r_held  <= w_held_nxt;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state <= c_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                c_IDLE: begin
                    if (r_s2[i]) begin
                        w_state_nxt = c_CONF_PRESS;
                        w_cnt_nxt   = c_CNT_ONE;
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                c_CONF_PRESS: begin
                    if (!r_s2[i]) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        w_state_nxt = c_HELD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    end
                end
                c_HELD: begin
                    if (!r_s2[i]) begin
                        w_state_nxt = c_CONF_REL;
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end
                c_CONF_REL: begin
                    // A return to 1 here is release bounce: back to HELD silently.
                    if (r_s2[i]) begin
                        w_state_nxt = c_HELD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_fire[i]     = (r_state == c_CONF_PRESS) && r_s2[i] && (r_cnt == c_CNT_MAX);
        assign w_held_nxt[i] = (w_state_nxt == c_HELD) || (w_state_nxt == c_CONF_REL);
    end

`ifdef TIE_CANCEL_EN
    logic w_tie;
    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign w_tie       = |(w_fire & (w_fire - N_KEYS'(1)));
    assign w_pulse_nxt = w_tie ? '0 : w_fire;
`else
    assign w_pulse_nxt = w_fire;
`endif

    assign press_pulse = r_pulse;
    assign held        = r_held;

endmodule
`default_nettype wire

// File: tb/tb_press_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_press_conditioner
// Brief    : Directed self-checking bench for press_conditioner (2 keys, 4 samples).
// Revision : 1.0 - initial release
// ============================================================================
module tb_press_conditioner;

    logic       clk;
    logic       reset;
    logic [1:0] key_raw;
    logic [1:0] press_pulse;
    logic [1:0] held;

    int checks = 0;
    int errors = 0;

    press_conditioner #(
        .N_KEYS          (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_raw     (key_raw),
        .press_pulse (press_pulse),
        .held        (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    logic [1:0] tie_exp;

    initial begin
`ifdef TIE_CANCEL_EN
        tie_exp = 2'b00;
`else
        tie_exp = 2'b11;
`endif
        // Reset held low with both keys pressed
        reset   = 1'b0;
        key_raw = 2'b11;
        #2;
        chk("reset_pulse_async", press_pulse, 2'b00);
        chk("reset_held_async",  held,        2'b00);
        for (int k = 1; k <= 2; k++) begin
            tick();
            chk("reset_pulse", press_pulse, 2'b00);
            chk("reset_held",  held,        2'b00);
        end
        key_raw = 2'b00;
        reset   = 1'b1;
        idle_cycles(4);
        chk("post_reset_pulse", press_pulse, 2'b00);
        chk("post_reset_held",  held,        2'b00);

        // Clean press: 20 cycles high; pulse after edge 6, held falls at edge 26
        for (int k = 1; k <= 30; k++) begin
            key_raw = (k <= 20) ? 2'b01 : 2'b00;
            tick();
            chk("clean_pulse", press_pulse, (k == 6) ? 2'b01 : 2'b00);
            chk("clean_held",  held, (k >= 6 && k <= 25) ? 2'b01 : 2'b00);
        end
        idle_cycles(4);

        // Glitch: two samples high only
        for (int k = 1; k <= 10; k++) begin
            key_raw = (k <= 2) ? 2'b01 : 2'b00;
            tick();
            chk("glitch_pulse", press_pulse, 2'b00);
            chk("glitch_held",  held,        2'b00);
        end
        idle_cycles(4);

        // Release bounce: high to 11, then 0,1,0,1,0, quiet from 16
        for (int k = 1; k <= 28; k++) begin
            if (k <= 11)      key_raw = 2'b01;
            else if (k >= 16) key_raw = 2'b00;
            else              key_raw = (k % 2 == 1) ? 2'b01 : 2'b00;
            tick();
            chk("bounce_pulse", press_pulse, (k == 6) ? 2'b01 : 2'b00);
            chk("bounce_held",  held, (k >= 6 && k <= 20) ? 2'b01 : 2'b00);
        end
        idle_cycles(4);

        // Reset during CONF_PRESS; key stays held through reset
        key_raw = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("midrst_pre_pulse", press_pulse, 2'b00);
        end
        reset = 1'b0;
        #1;
        chk("midrst_async_pulse", press_pulse, 2'b00);
        chk("midrst_async_held",  held,        2'b00);
        tick();
        chk("midrst_in_reset_pulse", press_pulse, 2'b00);
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("midrst_pulse", press_pulse, (k == 6) ? 2'b10 : 2'b00);
            chk("midrst_held",  held, (k >= 6) ? 2'b10 : 2'b00);
        end
        key_raw = 2'b00;
        idle_cycles(10);
        chk("midrst_released_held", held, 2'b00);

        // Simultaneous press on both channels
        for (int k = 1; k <= 10; k++) begin
            key_raw = 2'b11;
            tick();
            chk("simul_pulse", press_pulse, (k == 6) ? tie_exp : 2'b00);
            chk("simul_held",  held, (k >= 6) ? 2'b11 : 2'b00);
        end
        key_raw = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("simul_rel_pulse", press_pulse, 2'b00);
            chk("simul_rel_held",  held, (k <= 5) ? 2'b11 : 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
